seq_shift_rotate_unit: RTL
==========================

# seq_shift_rotate_unit

Multi-cycle, parametrised shift/rotate engine for the datapath ALU. It generalises the single-cycle rotate-right path to five modes (SHR, SHRA, SHL, ROR, ROL), a configurable data width, and a configurable number of bit positions shifted per cycle. It sits beside the combinational ALU and is controlled by a start/done handshake from the control sequencer. The result is written back through the Z path.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- STEP, 1: maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, 5: shift-amount width; must equal log2(WIDTH).

- Clock  in  1  rising-edge clock; only clock.
- Clear  in  1  one clock; reset is synchronous and active-low (Clear=0 at a rising Clock edge resets).
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101–111 pass-through.
- operand  in  WIDTH  value to shift; captured with start.
- shamt  in  SHAMT_W  shift amount 0..WIDTH-1; captured with start.
- abort  in  1  present only with SEQ_SHIFT_ABORT_EN.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse, high in DONE.
- result  out  WIDTH  shifted value; holds until next accepted start or reset.
- carry_out  out  1  last bit shifted or rotated out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1, capture operand, mode, shamt and clear carry_out.
  - If shamt=0 or mode is pass-through, go to DONE with result=operand.
  - Otherwise go to SHIFT with the working register set to operand and remaining set to shamt.
- SHIFT: each cycle, shift by k = min(STEP, remaining) and decrement remaining by k.
  - carry_out takes the last bit that crossed the boundary:
    - SHR/SHRA/ROR: original bit k-1 of the working value.
    - SHL/ROL: bit WIDTH-k.
  - SHR fills with 0. SHRA fills with the captured sign bit. SHL fills LSBs with 0.
  - ROR/ROL wrap the bits around.
  - When remaining reaches 0, go to DONE.
- DONE: done=1 and result is valid.
  - If start=1, accept the new request exactly as IDLE does (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- start during SHIFT is ignored; no queuing.
- All arithmetic is modulo WIDTH; shamt never exceeds WIDTH-1 by construction.
- The result register updates only in SHIFT, and when start is accepted on the zero-shift or pass-through path.

## Timing
- Reset values: busy=0, done=0, result=0, carry_out=0, state=IDLE.
- Clear=0 mid-SHIFT abandons the operation with no done pulse. Reset has priority over start and abort.
- Latency, start edge to done: 1 cycle for shamt=0 or pass-through; otherwise ceil(shamt/STEP)+1 cycles.
- busy is high for exactly ceil(shamt/STEP) cycles.
- Throughput: one operation per ceil(shamt/STEP)+1 cycles, because start is accepted in DONE.
- done never coincides with busy.

## Configuration
- SEQ_SHIFT_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in SHIFT returns to IDLE on the next edge with no done pulse. result and carry_out keep their partial values.
  - abort is ignored in IDLE and DONE, and abort takes precedence over completing the shift.
- Not defined: the port is absent and every shift runs to completion.

## Test plan
- WIDTH=32, STEP=1: ROR 0x00000012 by 4 → result 0x20000001, carry_out=0, busy for 4 cycles, done pulse 5 cycles after start.
- Same ROR with STEP=4 → identical result; busy for 1 cycle, done 2 cycles after start. SHL 0x00000001 by 31 with STEP=8 → 0x80000000, busy for 4 cycles, carry_out=0.
- SHRA 0x80000000 by 31 → 0xFFFFFFFF, carry_out=0. ROL 0x80000001 by 1 → 0x00000003, carry_out=1. SHR 0x80000001 by 1 → 0x40000000, carry_out=1.
- shamt=0 and mode=111 → result=operand, done 1 cycle after start, busy never high. A back-to-back start during DONE is accepted with no idle cycle.
- Clear=0 during the second SHIFT cycle → next edge: result=0, busy=0, no done pulse. start during SHIFT → ignored, and the first result completes unchanged.
- With SEQ_SHIFT_ABORT_EN: abort during SHIFT → IDLE next cycle, no done pulse. A new start then completes normally.

Source files
------------

// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate engine (SHR, SHRA, SHL, ROR, ROL) with start/done handshake.
// Optional abort input is compiled in when SEQ_SHIFT_ABORT_EN is defined.
module seq_shift_rotate_unit #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = 5
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SEQ_SHIFT_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] MODE_SHR  = 3'd0;
  localparam logic [2:0] MODE_SHRA = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;

  localparam logic [SHAMT_W:0]   STEP_EXT    = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W-1:0] SHAMT_ZERO  = SHAMT_W'(0);
  localparam logic [SHAMT_W-1:0] SHAMT_ONE   = SHAMT_W'(1);

  state_e               state_q,  state_d;
  logic [WIDTH-1:0]     work_q,   work_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]   rem_q,    rem_d;
  logic [2:0]           mode_q,   mode_d;
  logic                 sign_q,   sign_d;
  logic                 carry_q,  carry_d;

  logic [SHAMT_W-1:0]   k_s;
  logic [WIDTH-1:0]     shifted_s;
  logic                 cout_s;
  logic                 last_s;

  // One partial shift by k (1 <= k <= WIDTH-1); returns {carry, value}.
  // Right ops shift {fill, v} down, left ops shift {v, fill} up; the fill half
  // supplies zeros, sign copies or the wrapped bits.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0]   v,
                                                input logic [2:0]         m,
                                                input logic               sgn,
                                                input logic [SHAMT_W-1:0] k);
    logic [2*WIDTH-1:0] wide;
    logic [SHAMT_W-1:0] r_idx;
    logic [SHAMT_W-1:0] l_idx;
    logic [WIDTH:0]     res;
    r_idx = k - SHAMT_ONE;
    l_idx = SHAMT_ZERO - k;
    wide  = '0;
    res   = {1'b0, v};
    case (m)
      MODE_SHR: begin
        wide = {{WIDTH{1'b0}}, v} >> k;
        res  = {v[r_idx], wide[WIDTH-1:0]};
      end
      MODE_SHRA: begin
        wide = {{WIDTH{sgn}}, v} >> k;
        res  = {v[r_idx], wide[WIDTH-1:0]};
      end
      MODE_ROR: begin
        wide = {v, v} >> k;
        res  = {v[r_idx], wide[WIDTH-1:0]};
      end
      MODE_SHL: begin
        wide = {v, {WIDTH{1'b0}}} << k;
        res  = {v[l_idx], wide[2*WIDTH-1:WIDTH]};
      end
      MODE_ROL: begin
        wide = {v, v} << k;
        res  = {v[l_idx], wide[2*WIDTH-1:WIDTH]};
      end
      default: res = {1'b0, v};
    endcase
    return res;
  endfunction

  // Per-cycle step size and the shifted working value.
  always_comb begin
    if ({1'b0, rem_q} > STEP_EXT) begin
      k_s = STEP_EXT[SHAMT_W-1:0];
    end else begin
      k_s = rem_q;
    end
    last_s              = ({1'b0, rem_q} <= STEP_EXT);
    {cout_s, shifted_s} = shift_step(work_q, mode_q, sign_q, k_s);
  end

  // State and datapath registers, synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      mode_q   <= 3'd0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state and datapath update; DONE accepts start exactly like IDLE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          sign_d  = operand[WIDTH-1];
          carry_d = 1'b0;
          work_d  = operand;
          rem_d   = shamt;
          if ((shamt == SHAMT_ZERO) || (mode > MODE_ROL)) begin
            result_d = operand;
            state_d  = S_DONE;
          end else begin
            state_d  = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
`ifdef SEQ_SHIFT_ABORT_EN
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          work_d   = shifted_s;
          result_d = shifted_s;
          carry_d  = cout_s;
          rem_d    = rem_q - k_s;
          if (last_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
`else
        work_d   = shifted_s;
        result_d = shifted_s;
        carry_d  = cout_s;
        rem_d    = rem_q - k_s;
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy      = (state_q == S_SHIFT);
    done      = (state_q == S_DONE);
    result    = result_q;
    carry_out = carry_q;
  end

endmodule
